// File: rtl/timer_sched.sv
// timer_sched: round-robin arbiter time-sharing one prescaled down-counter
// among N requesters. A winner's prescaler/reload pair is loaded once, the
// delay runs to completion (or until the requester withdraws), and a
// single-cycle acknowledge is returned to that requester.
module timer_sched #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int PW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [N*PW-1:0]      psc_in,
  input  logic [N*W-1:0]       reload_in,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(N)-1:0] idx,
  output logic [W-1:0]         cnt
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;

  // First pending request strictly after the last winner, wrapping modulo N;
  // the last winner itself is examined last so it cannot starve the others.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [IW-1:0] l);
    logic found;
    int   j;
    rr_pick = l;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(l) + k) % N;
      if (!found && r[j]) begin
        rr_pick = IW'(j);
        found   = 1'b1;
      end
    end
  endfunction

  // Next-state, datapath and registered-output decode for the scheduler.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    psc_d   = psc_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    ack_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, last_q);
          last_d  = idx_d;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!req[idx_q]) begin
          // requester withdrew: drop everything, keep last for fairness
          state_d = S_IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end else begin
          psc_d   = psc_in[idx_q*PW +: PW];
          cnt_d   = reload_in[idx_q*W +: W];
          pre_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[idx_q]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end else if (en) begin
          if (pre_q == psc_q) begin
            pre_d = '0;
            if (cnt_q == '0) begin
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q - W'(1);
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end else begin
          // en low: prescaler, counter and state all frozen
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pre_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the flops line up with it.
    if ((state_d == S_LOAD) || (state_d == S_RUN)) begin
      gnt_d[idx_d] = 1'b1;
    end else if (state_d == S_DONE) begin
      ack_d[idx_d] = 1'b1;
    end else begin
      gnt_d = '0;
      ack_d = '0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= IW'(N - 1);
      last_q  <= IW'(N - 1);
      psc_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      psc_q   <= psc_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != S_IDLE);
  assign idx  = idx_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: reset values, delay timing, corner
// prescaler/reload values, round-robin order, pause, abort, mid-run reset.
module tb_timer_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int PW = 5;

  logic            clk;
  logic            reset;
  logic            en;
  logic [N-1:0]    req;
  logic [N*PW-1:0] psc_in;
  logic [N*W-1:0]  reload_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            busy;
  logic [1:0]      idx;
  logic [W-1:0]    cnt;

  int n_pass;
  int n_total;
  int n;
  logic [N-1:0] g_seen;

  timer_sched #(.N(N), .W(W), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .psc_in    (psc_in),
    .reload_in (reload_in),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy),
    .idx       (idx),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Steps until ack is seen (bounded); n = number of steps taken.
  task automatic wait_ack(output int steps);
    steps = 0;
    do begin
      step();
      steps = steps + 1;
    end while ((ack == '0) && (steps < 3000));
    chk("ack_seen", {31'd0, (ack != '0)}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    en        = 1'b1;
    req       = 4'b0000;
    psc_in    = '0;
    reload_in = '0;
    do_reset();

    // reset state
    chk("rst_gnt",  {28'd0, gnt}, 32'd0);
    chk("rst_ack",  {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt",  {16'd0, cnt}, 32'd0);
    chk("rst_idx",  {30'd0, idx}, 32'd3);

    // test 1: ch0, psc=3, reload=0x13 -> 80 RUN cycles
    psc_in[0*PW +: PW]   = 5'd3;
    reload_in[0*W +: W]  = 16'h0013;
    req = 4'b0001;
    step();
    chk("t1_load_gnt",  {28'd0, gnt}, 32'h1);
    chk("t1_load_busy", {31'd0, busy}, 32'd1);
    chk("t1_load_idx",  {30'd0, idx}, 32'd0);
    step();
    chk("t1_run_cnt", {16'd0, cnt}, 32'h13);
    repeat (4) step();
    chk("t1_cnt_step", {16'd0, cnt}, 32'h12);
    chk("t1_run_gnt",  {28'd0, gnt}, 32'h1);
    wait_ack(n);
    chk("t1_run_len", n, 32'd76);
    chk("t1_ack",     {28'd0, ack}, 32'h1);
    chk("t1_done_gnt", {28'd0, gnt}, 32'h0);
    chk("t1_done_cnt", {16'd0, cnt}, 32'h0);
    req = 4'b0000;
    step();
    chk("t1_ack_once", {28'd0, ack}, 32'h0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // test 2a: ch1, psc=0, reload=0 -> ack on 3rd cycle
    psc_in[1*PW +: PW]  = 5'd0;
    reload_in[1*W +: W] = 16'h0000;
    req = 4'b0010;
    step();
    chk("t2_c1_ack", {28'd0, ack}, 32'h0);
    chk("t2_c1_gnt", {28'd0, gnt}, 32'h2);
    step();
    chk("t2_c2_ack", {28'd0, ack}, 32'h0);
    step();
    chk("t2_c3_ack", {28'd0, ack}, 32'h2);
    req = 4'b0000;
    step();

    // test 2b: ch1, psc=31, reload=1 -> 64 RUN cycles
    psc_in[1*PW +: PW]  = 5'd31;
    reload_in[1*W +: W] = 16'h0001;
    req = 4'b0010;
    step();
    step();
    chk("t2b_cnt", {16'd0, cnt}, 32'h1);
    wait_ack(n);
    chk("t2b_run_len", n, 32'd64);
    chk("t2b_ack", {28'd0, ack}, 32'h2);
    req = 4'b0000;
    step();

    // test 3: all four requesting, 2-cycle delays, order 0,1,2,3,0
    do_reset();
    for (int c = 0; c < N; c++) begin
      psc_in[c*PW +: PW]  = 5'd0;
      reload_in[c*W +: W] = 16'h0001;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        step();
        n = n + 1;
      end while ((gnt == '0) && (n < 20));
      g_seen = gnt;
      chk("t3_gnt_order", {28'd0, g_seen}, 32'(1 << (k % N)));
      wait_ack(n);
      chk("t3_len", n, 32'd3);
      chk("t3_ack_match", {28'd0, ack}, {28'd0, g_seen});
    end
    req = 4'b0000;
    step();
    step();

    // test 4: test 1 with a 10-cycle pause -> 90 RUN cycles
    psc_in[0*PW +: PW]  = 5'd3;
    reload_in[0*W +: W] = 16'h0013;
    req = 4'b0001;
    step();
    step();
    repeat (20) step();
    chk("t4_pre_pause_cnt", {16'd0, cnt}, 32'h0E);
    en = 1'b0;
    repeat (10) step();
    chk("t4_pause_cnt", {16'd0, cnt}, 32'h0E);
    chk("t4_pause_gnt", {28'd0, gnt}, 32'h1);
    chk("t4_pause_ack", {28'd0, ack}, 32'h0);
    en = 1'b1;
    wait_ack(n);
    chk("t4_remaining", n, 32'd60);
    chk("t4_ack", {28'd0, ack}, 32'h1);
    req = 4'b0000;
    step();

    // test 5: abort ch2 at RUN cycle 5, pending ch3 then served
    psc_in[2*PW +: PW]  = 5'd3;
    reload_in[2*W +: W] = 16'h0013;
    psc_in[3*PW +: PW]  = 5'd0;
    reload_in[3*W +: W] = 16'h0000;
    req = 4'b1100;
    step();
    chk("t5_gnt2", {28'd0, gnt}, 32'h4);
    repeat (5) step();
    chk("t5_run_gnt", {28'd0, gnt}, 32'h4);
    req = 4'b1000;
    step();
    chk("t5_abort_gnt",  {28'd0, gnt}, 32'h0);
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_abort_ack",  {28'd0, ack}, 32'h0);
    chk("t5_abort_cnt",  {16'd0, cnt}, 32'h0);
    step();
    chk("t5_gnt3", {28'd0, gnt}, 32'h8);
    chk("t5_idx3", {30'd0, idx}, 32'd3);
    wait_ack(n);
    chk("t5_ack3", {28'd0, ack}, 32'h8);
    req = 4'b0000;
    step();

    // test 6: asynchronous reset mid-RUN at cnt=7
    psc_in[0*PW +: PW]  = 5'd0;
    reload_in[0*W +: W] = 16'h000A;
    req = 4'b0001;
    step();
    step();
    repeat (3) step();
    chk("t6_cnt7", {16'd0, cnt}, 32'h7);
    reset = 1'b1;
    #1;
    chk("t6_async_cnt",  {16'd0, cnt}, 32'h0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_idx",  {30'd0, idx}, 32'd3);
    chk("t6_async_gnt",  {28'd0, gnt}, 32'h0);
    req = 4'b1000;
    step();
    reset = 1'b0;
    step();
    chk("t6_gnt3", {28'd0, gnt}, 32'h8);
    wait_ack(n);
    chk("t6_ack3", {28'd0, ack}, 32'h8);
    req = 4'b1001;
    step();
    step();
    chk("t6_rr_gnt0", {28'd0, gnt}, 32'h1);
    chk("t6_rr_idx0", {30'd0, idx}, 32'd0);
    req = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Round-robin scheduler that time-shares one prescaled 16-bit down-counter timer among N requesters.
- Each requester presents its own prescaler and reload configuration. The block grants the timer to one requester, loads that requester's configuration, runs the delay, then returns a one-cycle acknowledge to it.
- Sits between software-visible delay channels and the shared timer datapath. The timer is contained inside this block.

Parameters:
- N, 4, number of requesters (2..8)
- W, 16, counter/reload width
- PW, 5, prescaler width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  global count enable; low freezes prescaler and counter
- req  input  N  request per channel; held high until that channel's ack
- psc_in  input  N*PW  prescaler value; channel i at bits [i*PW +: PW]
- reload_in  input  N*W  reload value; channel i at bits [i*W +: W]
- gnt  output  N  one-hot grant, high during LOAD and RUN
- ack  output  N  one-hot, one-cycle completion pulse
- busy  output  1  high in any state other than IDLE
- idx  output  $clog2(N)  index of granted or last-granted channel
- cnt  output  W  current counter value

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state=IDLE
  - gnt=0, ack=0, busy=0, cnt=0, idx=N-1
  - internal prescaler count pre=0
  - round-robin pointer last=N-1, so channel 0 has top priority after reset.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE, when any req bit is high:
  - Select the first set bit scanning last+1, last+2, ... modulo N.
  - Register the result into idx and last. Go to LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD (1 cycle):
  - Latch psc_r=psc_in[idx], and cnt=reload_in[idx]; clear pre=0.
  - gnt[idx]=1. Go to RUN.
  - Inputs are sampled only here; changes during RUN are ignored.
- RUN, each cycle with en=1:
  - If pre==psc_r: pre<=0, and either
    - cnt==0: go to DONE, or
    - otherwise cnt<=cnt-1.
  - Else pre<=pre+1.
- RUN with en=0: pre, cnt and state all hold. gnt stays high.
- RUN duration with en held high is exactly (reload+1)*(psc+1) cycles.
  - reload=0, psc=0 gives 1 RUN cycle.
  - Maximum is 65536*32 cycles. No overflow is possible: the prescaler compare is an equality test and the counter only decrements.
- DONE (1 cycle):
  - ack[idx]=1, gnt=0, cnt holds 0. Go to IDLE.
  - ack is asserted regardless of en.
- Latency at en=1: ack is high (reload+1)*(psc+1)+2 cycles after the first IDLE cycle that sees req.
- Abort: if req[idx] falls during LOAD or RUN, the next state is IDLE.
  - No ack is issued; gnt clears, cnt clears to 0, pre clears.
  - last keeps the aborted index.
- Requester protocol:
  - Drop req the cycle after ack.
  - A req still high in the following IDLE cycle is treated as a new request. Other pending channels win first because of the round-robin order.
- Simultaneous requests: exactly one is granted per cycle. The pointer guarantees each pending channel is served within N grants.
- Reset mid-RUN: immediate return to reset values; no ack is issued.
- Outputs are registered; ack and gnt never glitch. busy is derived from the registered state.

Test Plan:
1. Reset, then req=0001, psc0=3, reload0=0x0013, en=1 -> gnt=0001 for LOAD plus 80 RUN cycles; cnt steps 0x13 to 0 every 4 cycles; ack=0001 for exactly 1 cycle; then busy=0.
2. Corner values: req[1] with psc=0, reload=0 -> exactly 1 RUN cycle, ack[1] on the 3rd cycle after IDLE sees req. Then psc=31, reload=1 -> 64 RUN cycles.
3. req=1111 held after each ack, every delay 2 cycles -> grant order 0,1,2,3,0. Each ack is one-hot and matches the preceding gnt.
4. Pause: en=0 for 10 cycles mid-RUN of test 1 -> cnt and gnt frozen; ack arrives 10 cycles later (90 RUN cycles total).
5. Abort: drop req[2] at RUN cycle 5 -> next cycle IDLE, gnt=0, no ack. A pending req[3] is then granted.
6. Assert reset mid-RUN with cnt=0x0007 -> same-cycle asynchronous clear to cnt=0, busy=0, idx=N-1. After release, req=1000 is granted to channel 3, and channel 0 wins on the next contention.
